// File: rtl/apb_master_if.sv
`default_nettype none
// =============================================================================
// Module   : apb_master_if
// Brief    : APB bus bundle between one requester and its completer.
// Revision : 1.0
// =============================================================================
interface apb_master_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
);
    logic               p_sel;
    logic               p_enable;
    logic               p_write;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] p_wdata;
    logic [D_WIDTH-1:0] p_rdata;
    logic               p_ready;
    logic               p_slverr;

    modport master (
        output p_sel,
        output p_enable,
        output p_write,
        output p_addr,
        output p_wdata,
        input  p_rdata,
        input  p_ready,
        input  p_slverr
    );

    modport slave (
        input  p_sel,
        input  p_enable,
        input  p_write,
        input  p_addr,
        input  p_wdata,
        output p_rdata,
        output p_ready,
        output p_slverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// =============================================================================
// Module   : apb_master
// Brief    : APB requester taking single read/write commands and returning a
//            one-cycle response strobe. Define APB_TIMEOUT_EN to abort
//            transfers stuck in ACCESS for TIMEOUT wait cycles.
// Revision : 1.0
// =============================================================================
module apb_master #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int TIMEOUT = 16
) (
    input  wire logic               p_clk,
    input  wire logic               p_rst,

    input  wire logic               cmd_valid,
    output logic                    cmd_ready,
    input  wire logic               cmd_write,
    input  wire logic [A_WIDTH-1:0] cmd_addr,
    input  wire logic [D_WIDTH-1:0] cmd_wdata,

    output logic                    rsp_valid,
    output logic [D_WIDTH-1:0]      rsp_rdata,
    output logic                    rsp_err,

    apb_master_if.master            apb
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    generate
        if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
            $error("apb_master: TIMEOUT must lie in 2..255");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sel;
    logic               r_enable;
    logic               r_write;
    logic [A_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0] r_wdata;
    logic               r_rsp_valid;
    logic [D_WIDTH-1:0] r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_sel_nxt;
    logic               w_enable_nxt;
    logic               w_write_nxt;
    logic [A_WIDTH-1:0] w_addr_nxt;
    logic [D_WIDTH-1:0] w_wdata_nxt;
    logic               w_rsp_valid_nxt;
    logic [D_WIDTH-1:0] w_rsp_rdata_nxt;
    logic               w_rsp_err_nxt;

    logic               w_accept;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic       w_wait_expired;

    // True on the wait cycle whose increment would make the count hit TIMEOUT.
    assign w_wait_expired = (r_wait == c_WAIT_LAST);
`endif

    // Ready is the only combinational output so a reset cycle never accepts.
    assign cmd_ready = (r_state == ST_IDLE) && !p_rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_enable_nxt    = r_enable;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_TIMEOUT_EN
        w_wait_nxt      = r_wait;
`endif

        case (r_state)
            ST_IDLE: begin
                w_sel_nxt    = 1'b0;
                w_enable_nxt = 1'b0;
                if (w_accept) begin
                    w_write_nxt = cmd_write;
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_wdata;
                    w_sel_nxt   = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_sel_nxt    = 1'b1;
                w_enable_nxt = 1'b1;
                w_state_nxt  = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                w_wait_nxt   = 8'd0;
`endif
            end

            ST_ACCESS: begin
                if (apb.p_ready) begin
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = apb.p_slverr;
                    w_rsp_rdata_nxt = r_write ? '0 : apb.p_rdata;
                    w_state_nxt     = ST_IDLE;
                end else begin
`ifdef APB_TIMEOUT_EN
                    w_wait_nxt = r_wait + 8'd1;
                    if (w_wait_expired) begin
                        w_sel_nxt       = 1'b0;
                        w_enable_nxt    = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                        w_state_nxt     = ST_IDLE;
                    end
`endif
                end
            end

            default: begin
                w_sel_nxt    = 1'b0;
                w_enable_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait      <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_enable    <= w_enable_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef APB_TIMEOUT_EN
            r_wait      <= w_wait_nxt;
`endif
        end
    end

    assign apb.p_sel    = r_sel;
    assign apb.p_enable = r_enable;
    assign apb.p_write  = r_write;
    assign apb.p_addr   = r_addr;
    assign apb.p_wdata  = r_wdata;

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_apb_master
// Brief    : Self-checking bench for apb_master; acts as the APB completer.
// Revision : 1.0
// =============================================================================
module tb_apb_master;

    localparam int c_TIMEOUT = 8;

    logic       p_clk = 1'b0;
    logic       p_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    apb_master_if #(.A_WIDTH(8), .D_WIDTH(8)) bus ();

    apb_master #(.A_WIDTH(8), .D_WIDTH(8), .TIMEOUT(c_TIMEOUT)) dut (
        .p_clk     (p_clk),
        .p_rst     (p_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus.master)
    );

    always #5 p_clk = ~p_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: what the bus and response registers should be holding.
    logic       m_write;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge p_clk);
        @(negedge p_clk);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_rsp_valid", rsp_valid, 1'b0);
            check("idle_sel", bus.p_sel, 1'b0);
            check("idle_enable", bus.p_enable, 1'b0);
            check("idle_addr_hold", bus.p_addr, m_addr);
            check("idle_wdata_hold", bus.p_wdata, m_wdata);
            check("idle_write_hold", bus.p_write, m_write);
            check("idle_rdata_hold", rsp_rdata, m_rdata);
            check("idle_err_hold", rsp_err, m_err);
        end
    endtask

    // One complete transfer; completer inserts `waits` wait states, then answers rd/se.
    task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int waits, input logic [7:0] rd, input logic se);
        check("pre_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        check("setup_sel", bus.p_sel, 1'b1);
        check("setup_enable", bus.p_enable, 1'b0);
        check("setup_addr", bus.p_addr, a);
        check("setup_wdata", bus.p_wdata, d);
        check("setup_write", bus.p_write, w);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        step();
        for (int i = 0; i <= waits; i++) begin
            check("access_sel", bus.p_sel, 1'b1);
            check("access_enable", bus.p_enable, 1'b1);
            check("access_addr", bus.p_addr, a);
            check("access_wdata", bus.p_wdata, d);
            check("access_rsp_valid", rsp_valid, 1'b0);
            bus.p_ready  = (i == waits);
            bus.p_slverr = (i == waits) ? se : 1'($urandom);
            bus.p_rdata  = (i == waits) ? rd : 8'($urandom);
            step();
        end
        bus.p_ready  = 1'b0;
        bus.p_slverr = 1'($urandom);
        bus.p_rdata  = 8'($urandom);
        m_write = w;
        m_addr  = a;
        m_wdata = d;
        m_err   = se;
        m_rdata = w ? 8'h00 : rd;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, m_err);
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("done_sel", bus.p_sel, 1'b0);
        check("done_enable", bus.p_enable, 1'b0);
        check("done_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        int n_acc;
        p_rst        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = 8'h00;
        cmd_wdata    = 8'h00;
        bus.p_ready  = 1'b0;
        bus.p_slverr = 1'b0;
        bus.p_rdata  = 8'h00;
        m_write = 1'b0; m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00; m_err = 1'b0;

        // Reset state, with a command pending that must not be taken.
        cmd_valid = 1'b1;
        repeat (3) @(posedge p_clk);
        @(negedge p_clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_sel", bus.p_sel, 1'b0);
        check("rst_enable", bus.p_enable, 1'b0);
        check("rst_write", bus.p_write, 1'b0);
        check("rst_addr", bus.p_addr, 8'h00);
        check("rst_wdata", bus.p_wdata, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        cmd_valid = 1'b0;
        p_rst = 1'b0;
        #1;
        check("rst_release_ready", cmd_ready, 1'b1);

        // Directed transfers.
        run_xfer(1'b1, 8'h03, 8'h5A, 0, 8'hEE, 1'b0);
        idle_gap(1);
        run_xfer(1'b0, 8'h07, 8'h11, 3, 8'hC3, 1'b0);
        idle_gap(2);
        run_xfer(1'b0, 8'h09, 8'h00, 1, 8'h77, 1'b1);
        idle_gap(1);
        run_xfer(1'b1, 8'h0A, 8'hA5, 0, 8'h00, 1'b0);
        idle_gap(1);

        // Back-to-back: cmd_valid held across two commands.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h31;
        step();
        check("b2b_setup1_addr", bus.p_addr, 8'h30);
        cmd_write = 1'b0; cmd_addr = 8'h40; cmd_wdata = 8'h41;
        bus.p_ready = 1'b1; bus.p_rdata = 8'h9D; bus.p_slverr = 1'b0;
        step();
        check("b2b_access1_enable", bus.p_enable, 1'b1);
        check("b2b_access1_ready", cmd_ready, 1'b0);
        step();
        check("b2b_rsp1_valid", rsp_valid, 1'b1);
        check("b2b_rsp1_rdata", rsp_rdata, 8'h00);
        check("b2b_mid_cmd_ready", cmd_ready, 1'b1);
        check("b2b_mid_sel", bus.p_sel, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("b2b_setup2_sel", bus.p_sel, 1'b1);
        check("b2b_setup2_enable", bus.p_enable, 1'b0);
        check("b2b_setup2_addr", bus.p_addr, 8'h40);
        check("b2b_setup2_write", bus.p_write, 1'b0);
        check("b2b_rsp_cleared", rsp_valid, 1'b0);
        step();
        check("b2b_access2_enable", bus.p_enable, 1'b1);
        step();
        bus.p_ready = 1'b0;
        check("b2b_rsp2_valid", rsp_valid, 1'b1);
        check("b2b_rsp2_rdata", rsp_rdata, 8'h9D);
        check("b2b_rsp2_err", rsp_err, 1'b0);
        m_write = 1'b0; m_addr = 8'h40; m_wdata = 8'h41; m_rdata = 8'h9D; m_err = 1'b0;
        idle_gap(1);

        // Randomized transfers against the model.
        for (int t = 0; t < 24; t++) begin
            run_xfer(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                     8'($urandom), 1'($urandom));
            idle_gap(int'($urandom_range(1, 3)));
        end

        // Reset in the middle of an ACCESS wait.
        run_xfer(1'b0, 8'h55, 8'h00, 0, 8'hB6, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h00;
        step();
        cmd_valid = 1'b0;
        bus.p_ready = 1'b0;
        step();
        step();
        check("midrst_waiting", bus.p_enable, 1'b1);
        p_rst = 1'b1;
        step();
        check("midrst_sel", bus.p_sel, 1'b0);
        check("midrst_enable", bus.p_enable, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        p_rst = 1'b0;
        #1;
        check("midrst_release_ready", cmd_ready, 1'b1);
        m_write = 1'b0; m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00; m_err = 1'b0;
        idle_gap(2);

        // Completer that never answers.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; cmd_wdata = 8'h00;
        step();
        cmd_valid = 1'b0;
        step();
        n_acc = 0;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 40 && bus.p_enable === 1'b1; i++) begin
            bus.p_ready = 1'b0;
            bus.p_rdata = 8'($urandom) | 8'h01;
            n_acc++;
            step();
        end
        check("to_access_cycles", n_acc, c_TIMEOUT);
        check("to_rsp_valid", rsp_valid, 1'b1);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 8'h00);
        check("to_sel", bus.p_sel, 1'b0);
        m_write = 1'b0; m_addr = 8'h21; m_wdata = 8'h00; m_rdata = 8'h00; m_err = 1'b1;
        idle_gap(1);
        run_xfer(1'b0, 8'h22, 8'h00, c_TIMEOUT - 2, 8'h6B, 1'b0);
        idle_gap(1);
`else
        for (int i = 0; i < 120; i++) begin
            bus.p_ready = 1'b0;
            if (bus.p_enable === 1'b1 && bus.p_sel === 1'b1 && rsp_valid === 1'b0) n_acc++;
            step();
        end
        check("nto_access_cycles", n_acc, 120);
        bus.p_ready = 1'b1; bus.p_rdata = 8'h3C; bus.p_slverr = 1'b0;
        step();
        bus.p_ready = 1'b0;
        check("nto_rsp_valid", rsp_valid, 1'b1);
        check("nto_rsp_rdata", rsp_rdata, 8'h3C);
        check("nto_rsp_err", rsp_err, 1'b0);
        m_write = 1'b0; m_addr = 8'h21; m_wdata = 8'h00; m_rdata = 8'h3C; m_err = 1'b0;
        idle_gap(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name:
apb_master

Overview:
- APB requester (initiator) that drives the bus consumed by the team's APB slave/memory blocks.
- Accepts single read/write commands on a valid/ready command port.
- Sequences each command through the APB SETUP and ACCESS phases, and honours p_ready wait states.
- Returns read data and error status on a one-cycle response strobe.

Parameters:
- A_WIDTH, 8, APB address width.
- D_WIDTH, 8, APB data width.
- TIMEOUT, 16, number of ACCESS-phase wait cycles before abort. Used only with APB_TIMEOUT_EN. Legal range 2..255.

Ports:
- p_clk  input  1  bus clock; all logic on the rising edge.
- p_rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  A_WIDTH  transfer address.
- cmd_wdata  input  D_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  D_WIDTH  read data; 0 for writes.
- rsp_err  output  1  transfer ended with p_slverr, or timed out.
- p_sel  output  1  APB select.
- p_enable  output  1  APB enable.
- p_write  output  1  APB direction.
- p_addr  output  A_WIDTH  APB address.
- p_wdata  output  D_WIDTH  APB write data.
- p_rdata  input  D_WIDTH  APB read data.
- p_ready  input  1  slave ready / end of wait states.
- p_slverr  input  1  slave error; sampled only when p_ready is high in ACCESS.

Behaviour:
- Reset (p_rst high at an edge):
  - state = IDLE.
  - p_sel = p_enable = p_write = 0; p_addr = 0; p_wdata = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - cmd_ready = 0 while p_rst is high.
- Reset mid-transfer: p_sel and p_enable are low after the next edge, no response is issued, and the command is dropped.
- States: IDLE, SETUP, ACCESS. All outputs are registered, except cmd_ready = (state == IDLE) && !p_rst.
- IDLE:
  - p_sel = 0, p_enable = 0.
  - On cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into p_write/p_addr/p_wdata, set p_sel = 1, and go to SETUP.
- SETUP: exactly one cycle with p_sel = 1, p_enable = 0. p_ready is ignored. Go to ACCESS with p_enable = 1.
- ACCESS:
  - p_sel = 1, p_enable = 1. p_addr, p_write and p_wdata stay stable.
  - If p_ready is low, stay in ACCESS (wait state).
  - If p_ready is high:
    - Transfer completes at that edge; p_sel = 0 and p_enable = 0 next cycle; go to IDLE.
    - rsp_valid = 1 for exactly that next cycle.
    - rsp_err = p_slverr.
    - rsp_rdata = p_rdata for reads, 0 for writes.
- Response hold and clear: rsp_rdata and rsp_err hold until the next completion. rsp_valid has no backpressure.
- Throughput:
  - Minimum 3 cycles per transfer: IDLE, SETUP, ACCESS.
  - A new command may be accepted in the same IDLE cycle that rsp_valid is high.
- Bus between transfers: p_addr, p_wdata and p_write keep their last values while idle; only p_sel and p_enable return low.
- Protocol rule: p_enable is never high while p_sel is low.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With APB_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with p_ready low.
  - When it reaches TIMEOUT with p_ready still low, the transfer aborts at that edge.
  - The abort behaves as a completion with rsp_err = 1 and rsp_rdata = 0, then returns to IDLE.
  - p_ready high on the abort edge counts as a normal completion and takes priority.
- Without APB_TIMEOUT_EN: no counter exists and ACCESS waits indefinitely for p_ready.

Test Plan:
- Write 0x5A to 0x03, p_ready high in first ACCESS, cmd accepted at edge k:
  - p_sel high cycles k+1..k+2 with p_addr = 0x03, p_wdata = 0x5A, p_write = 1.
  - p_enable high cycle k+2 only.
  - rsp_valid at k+3 with rsp_err = 0, rsp_rdata = 0.
- Read 0x07 with 3 wait states, p_rdata = 0xC3 on the ready cycle:
  - p_enable high 4 cycles with address stable.
  - rsp_valid one cycle later with rsp_rdata = 0xC3, rsp_err = 0.
- Read with p_slverr = 1 on the ready cycle -> rsp_valid with rsp_err = 1. Next error-free transfer clears rsp_err to 0.
- cmd_valid held high for two commands -> second SETUP starts 3 cycles after the first, with rsp_valid and cmd_ready overlapping in the intermediate IDLE cycle.
- p_rst asserted during ACCESS wait -> p_sel = p_enable = 0 and state IDLE next cycle. No rsp_valid. cmd_ready returns 1 the cycle p_rst drops.
- APB_TIMEOUT_EN, TIMEOUT = 8, p_ready held low:
  - rsp_valid with rsp_err = 1, rsp_rdata = 0 after 8 wait cycles; bus deasserted.
  - Without the macro, p_enable stays high for 100+ cycles.
